// File: rtl/aes_link_pkg.sv
// Shared types and default sizing for the UART block link.
package aes_link_pkg;

    localparam int unsigned ClkDivDefault     = 16;
    localparam int unsigned BlockBytesDefault = 16;

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

endpackage

// File: rtl/aes_link_rx.sv
// UART receive framing: input synchronizer, bit sampling FSM, byte strobe and
// frame-error pulse.
module aes_link_rx
    import aes_link_pkg::*;
#(
    parameter int unsigned CLK_DIV = ClkDivDefault
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);

    rx_state_e     r_state;
    logic [1:0]    r_sync;
    logic          r_rx_d;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_byte_valid;
    logic          r_frame_err;
    logic          w_rx;

    assign w_rx         = r_sync[1];
    assign o_byte       = r_shift;
    assign o_byte_valid = r_byte_valid;
    assign o_frame_err  = r_frame_err;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync       <= 2'b11;
            r_rx_d       <= 1'b1;
            r_state      <= RxIdle;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], i_rx};
            r_rx_d       <= w_rx;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                RxIdle: begin
                    if (r_rx_d && !w_rx) begin
                        r_state <= RxStart;
                        r_cnt   <= '0;
                    end
                end
                RxStart: begin
                    if (r_cnt == HALF_M1) begin
                        // A line already back high at mid start bit is a glitch.
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= w_rx ? RxIdle : RxData;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RxData: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= RxStop;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RxStop: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt        <= '0;
                        r_state      <= RxIdle;
                        r_byte_valid <= w_rx;
                        r_frame_err  <= !w_rx;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RxIdle;
            endcase
        end
    end

endmodule

// File: rtl/aes_uart_link.sv
// UART link for a block core: assembles received bytes into blocks and
// serialises result blocks onto io_tx, byte 0 first.
module aes_uart_link
    import aes_link_pkg::*;
#(
    parameter int unsigned CLK_DIV     = ClkDivDefault,
    parameter int unsigned BLOCK_BYTES = BlockBytesDefault
) (
    input  logic                     io_clk,
    input  logic                     io_reset,
    input  logic                     io_rx,
    output logic                     io_tx,
    output logic                     io_done,
    output logic [8*BLOCK_BYTES-1:0] in_data,
    output logic                     in_valid,
    input  logic                     in_ready,
    input  logic [8*BLOCK_BYTES-1:0] out_data,
    input  logic                     out_valid,
    output logic                     out_ready,
    output logic                     frame_err,
    output logic                     overrun
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam int unsigned IW = $clog2(BLOCK_BYTES + 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(BLOCK_BYTES - 1);

    logic [7:0] w_rx_byte;
    logic       w_rx_valid;
    logic       w_accept;

    logic [8*BLOCK_BYTES-1:0] r_in_data;
    logic                     r_in_valid;
    logic [IW-1:0]            r_rx_idx;
    logic                     r_overrun;

    tx_state_e                r_tx_state;
    logic [8*BLOCK_BYTES-1:0] r_blk;
    logic [CW-1:0]            r_tx_cnt;
    logic [2:0]               r_tx_bit;
    logic [IW-1:0]            r_tx_idx;
    logic                     r_tx;
    logic                     r_done;
    logic                     r_out_ready;

    aes_link_rx #(
        .CLK_DIV(CLK_DIV)
    ) u_rx (
        .i_clk       (io_clk),
        .i_rst_n     (io_reset),
        .i_rx        (io_rx),
        .o_byte      (w_rx_byte),
        .o_byte_valid(w_rx_valid),
        .o_frame_err (frame_err)
    );

    assign w_accept  = r_in_valid && in_ready;
    assign in_data   = r_in_data;
    assign in_valid  = r_in_valid;
    assign overrun   = r_overrun;
    assign io_tx     = r_tx;
    assign io_done   = r_done;
    assign out_ready = r_out_ready;

    always_ff @(posedge io_clk) begin
        if (!io_reset) begin
            r_in_data  <= '0;
            r_in_valid <= 1'b0;
            r_rx_idx   <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_accept) begin
                r_in_valid <= 1'b0;
            end
            if (w_rx_valid) begin
                // Index is already 0 while a block is pending, so an accept in the
                // same cycle makes this byte the first of the next block.
                if (!r_in_valid || w_accept) begin
                    for (int unsigned k = 0; k < BLOCK_BYTES; k++) begin
                        if (r_rx_idx == IW'(k)) begin
                            r_in_data[8*k +: 8] <= w_rx_byte;
                        end
                    end
                    if (r_rx_idx == IDX_LAST) begin
                        r_in_valid <= 1'b1;
                        r_rx_idx   <= '0;
                    end else begin
                        r_rx_idx <= r_rx_idx + 1'b1;
                    end
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge io_clk) begin
        if (!io_reset) begin
            r_tx_state  <= TxIdle;
            r_blk       <= '0;
            r_tx_cnt    <= '0;
            r_tx_bit    <= '0;
            r_tx_idx    <= '0;
            r_tx        <= 1'b1;
            r_done      <= 1'b0;
            r_out_ready <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_tx_state)
                TxIdle: begin
                    r_out_ready <= 1'b1;
                    r_tx        <= 1'b1;
                    if (out_valid && r_out_ready) begin
                        r_blk       <= out_data;
                        r_tx        <= 1'b0;
                        r_out_ready <= 1'b0;
                        r_tx_cnt    <= '0;
                        r_tx_idx    <= '0;
                        r_tx_state  <= TxStart;
                    end
                end
                TxStart: begin
                    if (r_tx_cnt == FULL_M1) begin
                        // Shifting one bit per data slot leaves the next byte at [7:0].
                        r_tx_cnt   <= '0;
                        r_tx       <= r_blk[0];
                        r_blk      <= r_blk >> 1;
                        r_tx_bit   <= '0;
                        r_tx_state <= TxData;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TxData: begin
                    if (r_tx_cnt == FULL_M1) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_tx       <= 1'b1;
                            r_tx_state <= TxStop;
                        end else begin
                            r_tx     <= r_blk[0];
                            r_blk    <= r_blk >> 1;
                            r_tx_bit <= r_tx_bit + 3'd1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TxStop: begin
                    if (r_tx_cnt == FULL_M1) begin
                        r_tx_cnt <= '0;
                        if (r_tx_idx == IDX_LAST) begin
                            r_tx_state  <= TxIdle;
                            r_done      <= 1'b1;
                            r_out_ready <= 1'b1;
                        end else begin
                            r_tx_idx   <= r_tx_idx + 1'b1;
                            r_tx       <= 1'b0;
                            r_tx_state <= TxStart;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_state <= TxIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_uart_link.sv
// Randomized bench for aes_uart_link at CLK_DIV=4, BLOCK_BYTES=2 against a
// byte-queue receive model and a slot-arithmetic transmit model.
module tb_aes_uart_link;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned BB      = 2;
    localparam int unsigned FRAME   = 10 * CLK_DIV;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rx;
    logic            tx;
    logic            done;
    logic [8*BB-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [8*BB-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            frame_err;
    logic            overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int n_ferr   = 0;
    int n_ovr    = 0;
    int n_done   = 0;

    // Receive reference model: completed bytes queue up until a block is full.
    logic [7:0]      mdl_q[$];
    logic            mdl_pending = 1'b0;
    logic [8*BB-1:0] mdl_block   = '0;
    int              exp_ferr    = 0;
    int              exp_ovr     = 0;

    aes_uart_link #(
        .CLK_DIV    (CLK_DIV),
        .BLOCK_BYTES(BB)
    ) dut (
        .io_clk   (clk),
        .io_reset (rst_n),
        .io_rx    (rx),
        .io_tx    (tx),
        .io_done  (done),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
        if (done) n_done++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void mdl_rx(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            exp_ferr++;
        end else if (mdl_pending) begin
            exp_ovr++;
        end else begin
            mdl_q.push_back(b);
            if (mdl_q.size() == BB) begin
                for (int k = 0; k < BB; k++) mdl_block[8*k +: 8] = mdl_q[k];
                mdl_pending = 1'b1;
                mdl_q.delete();
            end
        end
    endfunction

    // Drive one UART frame, then a short idle gap so the byte has landed on return.
    task automatic rx_byte(input logic [7:0] b, input bit stop_ok);
        logic [9:0] frame;
        frame = {stop_ok, b, 1'b0};
        for (int s = 0; s < 10; s++) begin
            rx = frame[s];
            repeat (CLK_DIV) tick();
        end
        rx = 1'b1;
        repeat (4) tick();
        mdl_rx(b, stop_ok);
    endtask

    task automatic chk_rx(input string tag);
        chk({tag, "_valid"}, in_valid, mdl_pending);
        if (mdl_pending) chk({tag, "_data"}, in_data, mdl_block);
        chk({tag, "_ferr"}, n_ferr, exp_ferr);
        chk({tag, "_ovr"}, n_ovr, exp_ovr);
    endtask

    task automatic accept(input string tag);
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        mdl_pending = 1'b0;
        chk({tag, "_cleared"}, in_valid, 1'b0);
    endtask

    function automatic logic exp_tx_bit(input logic [8*BB-1:0] d, input int i);
        int byte_i;
        int slot;
        byte_i = i / FRAME;
        slot   = (i / CLK_DIV) % 10;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return d[8*byte_i + slot - 1];
    endfunction

    task automatic tx_block(input logic [8*BB-1:0] d, input string tag);
        int waited = 0;
        int errs   = 0;
        int first  = -1;
        int done0;
        while (out_ready !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        chk({tag, "_rdy"}, out_ready, 1'b1);
        if (out_ready !== 1'b1) return;
        done0     = n_done;
        out_data  = d;
        out_valid = 1'b1;
        tick();
        out_valid = 1'b0;
        out_data  = 16'($urandom);
        for (int i = 0; i < BB * FRAME; i++) begin
            if (tx !== exp_tx_bit(d, i)) begin
                errs++;
                if (first < 0) first = i;
            end
            tick();
        end
        chk({tag, "_wave_errs"}, errs, 0);
        chk({tag, "_first_bad"}, first, -1);
        chk({tag, "_early_done"}, n_done, done0);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_rdy_after"}, out_ready, 1'b1);
        tick();
        chk({tag, "_done_once"}, n_done, done0 + 1);
        chk({tag, "_done_low"}, done, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        rx        = 1'b1;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        repeat (3) tick();
        chk("rst_tx", tx, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_in_valid", in_valid, 1'b0);
        chk("rst_out_ready", out_ready, 1'b0);
        chk("rst_in_data", in_data, '0);
        chk("rst_pulses", {frame_err, overrun}, 2'b00);
        rst_n = 1'b1;
        tick();
        chk("rel_out_ready", out_ready, 1'b1);

        rx_byte(8'h3C, 1'b1);
        rx_byte(8'hA5, 1'b1);
        chk_rx("blk_a53c");
        chk("blk_a53c_const", in_data, 16'hA53C);
        repeat (10) tick();
        chk_rx("blk_a53c_hold");
        accept("blk_a53c");

        rx_byte(8'h55, 1'b0);
        chk_rx("ferr_55");
        rx_byte(8'h11, 1'b1);
        rx_byte(8'h22, 1'b1);
        chk_rx("blk_2211");
        chk("blk_2211_const", in_data, 16'h2211);

        rx_byte(8'h77, 1'b1);
        chk_rx("ovr_77");
        chk("ovr_77_const", in_data, 16'h2211);
        accept("ovr_77");

        rx = 1'b0;
        tick();
        rx = 1'b1;
        repeat (20) tick();
        chk_rx("glitch");
        rx_byte(8'($urandom), 1'b1);
        rx_byte(8'($urandom), 1'b1);
        chk_rx("after_glitch");
        accept("after_glitch");

        for (int it = 0; it < 8; it++) begin
            rx_byte(8'($urandom), $urandom_range(0, 4) != 0);
            chk_rx($sformatf("rand_rx%0d", it));
            if (mdl_pending && $urandom_range(0, 1) == 1) accept($sformatf("rand_rx%0d", it));
        end
        if (mdl_pending) accept("rand_rx_end");

        tx_block(16'h80F1, "tx_80f1");
        for (int it = 0; it < 2; it++) tx_block(16'($urandom), $sformatf("rand_tx%0d", it));

        fork
            begin
                rx_byte(8'($urandom), 1'b1);
                rx_byte(8'($urandom), 1'b1);
            end
            tx_block(16'($urandom), "conc_tx");
        join
        chk_rx("conc_rx");
        accept("conc_rx");

        // Partial receive block and a transmit in its data bits are both aborted.
        rx_byte(8'($urandom), 1'b1);
        begin
            int done0;
            done0     = n_done;
            out_data  = 16'h00FF;
            out_valid = 1'b1;
            tick();
            out_valid = 1'b0;
            repeat (CLK_DIV + 6) tick();
            chk("mid_rst_pre_tx", tx, 1'b1);
            rst_n = 1'b0;
            tick();
            chk("mid_rst_tx", tx, 1'b1);
            chk("mid_rst_rdy", out_ready, 1'b0);
            tick();
            rst_n = 1'b1;
            mdl_q.delete();
            mdl_pending = 1'b0;
            tick();
            chk("mid_rst_rdy_after", out_ready, 1'b1);
            repeat (BB * FRAME) tick();
            chk("mid_rst_no_done", n_done, done0);
            chk("mid_rst_tx_idle", tx, 1'b1);
        end
        rx_byte(8'($urandom), 1'b1);
        rx_byte(8'($urandom), 1'b1);
        chk_rx("post_rst_blk");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
